// File: rtl/popcnt_sched_pkg.sv
// popcnt_sched_pkg
// Shared types and helpers for the popcount scheduler slice.
//   state_t    : scheduler FSM states (IDLE, BUSY, HOLD)
//   STAT_W     : width of each per-requester grant counter
//   cnt_width  : bits needed to hold a count of 0..w ones
package popcnt_sched_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        HOLD = 2'd2
    } state_t;

    localparam int STAT_W = 16;

    function automatic int cnt_width(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/popcnt_core.sv
// popcnt_core
// Single-stage population count: the number of ones in data_i is
// registered on every edge where data_val_i is high.
// Ports:
//   clk_i      in  : clock, rising edge
//   arst_n_i   in  : asynchronous active-low reset
//   data_i     in  : WIDTH-bit word to count
//   data_val_i in  : data_i is to be captured this edge
//   data_o     out : registered count (0..WIDTH)
//   data_val_o out : data_o was captured on the previous edge
module popcnt_core
    import popcnt_sched_pkg::*;
#(
    parameter  int WIDTH = 16,
    localparam int CW    = cnt_width(WIDTH)
) (
    input  logic             clk_i,
    input  logic             arst_n_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             data_val_i,
    output logic [CW-1:0]    data_o,
    output logic             data_val_o
);

    logic [CW-1:0] ones_d;
    logic [CW-1:0] cnt_d;
    logic [CW-1:0] cnt_q;
    logic          val_d;
    logic          val_q;

    always_comb begin
        ones_d = '0;
        for (int i = 0; i < WIDTH; i++) begin
            ones_d = ones_d + CW'(data_i[i]);
        end
        // Hold the last count when idle so the output does not toggle needlessly.
        cnt_d = data_val_i ? ones_d : cnt_q;
        val_d = data_val_i;
    end

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            cnt_q <= '0;
            val_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            val_q <= val_d;
        end
    end

    assign data_o     = cnt_q;
    assign data_val_o = val_q;

endmodule

// File: rtl/popcnt_scheduler.sv
// popcnt_scheduler
// Shares one popcnt_core among N_REQ requesters. A round-robin arbiter
// grants one word at a time; each result is held in an output register,
// tagged with the requester ID, until the downstream accepts it.
// Optional feature macro: POPCNT_SCHED_STATS_EN (per-requester saturating
// 16-bit grant counters on stat_cnt_o).
// Ports:
//   clk_i       in  : clock, rising edge
//   arst_n_i    in  : asynchronous active-low reset
//   req_data_i  in  : requester words, requester k at [k*WIDTH +: WIDTH]
//   req_val_i   in  : per-requester valid
//   req_rdy_o   out : per-requester ready (one-hot or zero)
//   res_data_o  out : count of ones in the granted word
//   res_id_o    out : requester that produced the result
//   res_val_o   out : result valid
//   res_rdy_i   in  : downstream ready
//   stat_cnt_o  out : per-requester grant counters (stats build only)
module popcnt_scheduler
    import popcnt_sched_pkg::*;
#(
    parameter  int WIDTH = 16,
    parameter  int N_REQ = 4,
    localparam int CW    = cnt_width(WIDTH),
    localparam int IW    = $clog2(N_REQ)
) (
    input  logic                   clk_i,
    input  logic                   arst_n_i,
    input  logic [N_REQ*WIDTH-1:0] req_data_i,
    input  logic [N_REQ-1:0]       req_val_i,
    output logic [N_REQ-1:0]       req_rdy_o,
    output logic [CW-1:0]          res_data_o,
    output logic [IW-1:0]          res_id_o,
    output logic                   res_val_o,
    input  logic                   res_rdy_i
`ifdef POPCNT_SCHED_STATS_EN
    ,
    output logic [N_REQ*STAT_W-1:0] stat_cnt_o
`endif
);

    state_t            state_d, state_q;
    logic [IW-1:0]     last_d, last_q;
    logic [IW-1:0]     id_d, id_q;
    logic              res_val_d, res_val_q;
    logic [CW-1:0]     res_data_d, res_data_q;
    logic [IW-1:0]     res_id_d, res_id_q;

    logic              win_found;
    logic [IW-1:0]     win_idx;
    int                cand;
    logic              grant_en;
    logic              xfer;
    logic [WIDTH-1:0]  sel_word;
    logic [CW-1:0]     core_data;
    logic              core_val;

    // Round-robin search starting one past the last granted requester.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = 0;
        for (int i = 1; i <= N_REQ; i++) begin
            cand = (int'(last_q) + i) % N_REQ;
            if (!win_found && req_val_i[cand[IW-1:0]]) begin
                win_found = 1'b1;
                win_idx   = cand[IW-1:0];
            end
        end
    end

    // Word mux with constant slices only.
    always_comb begin
        sel_word = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (IW'(k) == win_idx) begin
                sel_word = req_data_i[k*WIDTH +: WIDTH];
            end
        end
    end

    // Next-state, grant and result-register logic.
    always_comb begin
        state_d    = state_q;
        last_d     = last_q;
        id_d       = id_q;
        res_val_d  = res_val_q;
        res_data_d = res_data_q;
        res_id_d   = res_id_q;
        req_rdy_o  = '0;
        grant_en   = 1'b0;

        case (state_q)
            IDLE: begin
                grant_en = 1'b1;
                if (win_found) begin
                    state_d = BUSY;
                end
            end
            BUSY: begin
                state_d = HOLD;
            end
            HOLD: begin
                if (res_rdy_i) begin
                    // Result leaves and the next word (if any) enters on the same edge.
                    grant_en  = 1'b1;
                    res_val_d = 1'b0;
                    state_d   = win_found ? BUSY : IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Ready is forced low while reset is held so no handshake can complete.
        xfer = grant_en && win_found && arst_n_i;
        if (xfer) begin
            req_rdy_o[win_idx] = 1'b1;
            last_d             = win_idx;
            id_d               = win_idx;
        end

        // The core output is valid exactly in BUSY; capture it with its tag.
        if (core_val) begin
            res_val_d  = 1'b1;
            res_data_d = core_data;
            res_id_d   = id_q;
        end
    end

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            state_q    <= IDLE;
            last_q     <= IW'(N_REQ - 1);
            id_q       <= '0;
            res_val_q  <= 1'b0;
            res_data_q <= '0;
            res_id_q   <= '0;
        end else begin
            state_q    <= state_d;
            last_q     <= last_d;
            id_q       <= id_d;
            res_val_q  <= res_val_d;
            res_data_q <= res_data_d;
            res_id_q   <= res_id_d;
        end
    end

    popcnt_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .clk_i      (clk_i),
        .arst_n_i   (arst_n_i),
        .data_i     (sel_word),
        .data_val_i (xfer),
        .data_o     (core_data),
        .data_val_o (core_val)
    );

    assign res_val_o  = res_val_q;
    assign res_data_o = res_data_q;
    assign res_id_o   = res_id_q;

`ifdef POPCNT_SCHED_STATS_EN
    // One saturating counter per requester, bumped on its handshake.
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_stat
        logic [STAT_W-1:0] stat_d;
        logic [STAT_W-1:0] stat_q;

        always_comb begin
            stat_d = stat_q;
            if (req_val_i[gi] && req_rdy_o[gi] && (stat_q != {STAT_W{1'b1}})) begin
                stat_d = stat_q + 1'b1;
            end
        end

        always_ff @(posedge clk_i or negedge arst_n_i) begin
            if (!arst_n_i) begin
                stat_q <= '0;
            end else begin
                stat_q <= stat_d;
            end
        end

        assign stat_cnt_o[gi*STAT_W +: STAT_W] = stat_q;
    end
`endif

endmodule
